// File: rtl/mul_wb_arbiter_pkg.sv
// Shared types and sizing constants for the multiplier/ALU write-back arbiter.
package mul_wb_arbiter_pkg;

  localparam int unsigned MUL_WB_FIFO_DEPTH = 4;
  localparam int unsigned MUL_WB_STARVE_MAX = 8;

  // Scalar exe-stage write-back record.
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        regfile_we;
    logic [63:0] result;
  } exe_wb_scalar_instr_t;

endpackage

// File: rtl/mul_wb_arbiter_if.sv
// Result streams in, shared write-back port and issue back-pressure out.
interface mul_wb_arbiter_if
  import mul_wb_arbiter_pkg::*;
  ();

  logic                 flush_i;
  exe_wb_scalar_instr_t mul_instr_i;
  exe_wb_scalar_instr_t alu_instr_i;
  exe_wb_scalar_instr_t wb_instr_o;
  logic                 mul_stall_o;
  logic                 alu_stall_o;

  modport slave (
    input  flush_i, mul_instr_i, alu_instr_i,
    output wb_instr_o, mul_stall_o, alu_stall_o
  );

  modport master (
    output flush_i, mul_instr_i, alu_instr_i,
    input  wb_instr_o, mul_stall_o, alu_stall_o
  );

endinterface

// File: rtl/mul_wb_arbiter_fifo.sv
// In-order buffer for multiplier results that lost the write-back port.
module mul_wb_fifo
  import mul_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MUL_WB_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  exe_wb_scalar_instr_t     data_i,
  input  logic                     pop_i,
  output exe_wb_scalar_instr_t     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [$clog2(DEPTH+1)-1:0] count_next_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  exe_wb_scalar_instr_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_next;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !flush_i && !empty_o;

  assign head_o       = mem[rd_ptr];
  assign count_o      = count_q;
  assign count_next_o = count_next;

  // Occupancy after this edge.
  always_comb begin
    count_next = count_q;
    if (push_ok && !pop_ok)      count_next = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_next = count_q - CW'(1);
    if (flush_i)                 count_next = '0;
  end

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_next;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/mul_wb_arbiter.sv
// Write-back arbiter: ALU results win, multiplier results queue in order
// and raise stalls toward issue to bound occupancy and starvation.
module mul_wb_arbiter
  import mul_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = MUL_WB_FIFO_DEPTH,
  parameter int unsigned STARVE_MAX = MUL_WB_STARVE_MAX
) (
  input logic          clk_i,
  input logic          rstn_i,
  mul_wb_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = $clog2(STARVE_MAX+1);

  exe_wb_scalar_instr_t head, wb;
  logic [CW-1:0] count, count_next;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [SW-1:0] starve_q, starve_next;
  logic          mul_stall_q, alu_stall_q;

  mul_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (bus.flush_i),
    .push_i       (push),
    .data_i       (bus.mul_instr_i),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Port select in priority order: flush, ALU, FIFO head, multiplier bypass.
  always_comb begin
    wb   = '0;
    push = 1'b0;
    pop  = 1'b0;
    if (bus.flush_i) begin
      wb = '0;
    end else if (bus.alu_instr_i.valid) begin
      wb   = bus.alu_instr_i;
      push = bus.mul_instr_i.valid;
    end else if (!fifo_empty) begin
      wb   = head;
      pop  = 1'b1;
      push = bus.mul_instr_i.valid;
    end else if (bus.mul_instr_i.valid) begin
      wb = bus.mul_instr_i;
    end
  end

  assign bus.wb_instr_o  = wb;
  assign bus.mul_stall_o = mul_stall_q;
  assign bus.alu_stall_o = alu_stall_q;

  // Head wait counter: counts cycles the ALU holds the port from a waiting head.
  always_comb begin
    starve_next = starve_q;
    if (bus.flush_i || fifo_empty || pop) begin
      starve_next = '0;
    end else if (bus.alu_instr_i.valid && starve_q != SW'(STARVE_MAX)) begin
      starve_next = starve_q + SW'(1);
    end
  end

  // Registered back-pressure; the occupancy threshold leaves room for two in-flight multiplies.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q    <= '0;
      mul_stall_q <= 1'b0;
      alu_stall_q <= 1'b0;
    end else begin
      starve_q    <= starve_next;
      mul_stall_q <= (count_next >= CW'(DEPTH-2));
      alu_stall_q <= (starve_next == SW'(STARVE_MAX));
    end
  end

  // A multiply arriving with no free slot and no departing head is dropped.
  overflow_chk: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push && fifo_full && !pop && !bus.flush_i))
    else $warning("mul_wb_arbiter: multiply result dropped, FIFO full");

endmodule

// File: doc/mul_wb_arbiter.md
# mul_wb_arbiter

Merges the non-stallable result stream of the two-stage multiplier with the integer ALU result stream onto one shared scalar write-back port in the exe stage. ALU results win the port unconditionally. Multiplier results that lose arbitration wait in a small in-order FIFO. The block raises back-pressure toward issue so that the FIFO never overflows and multiplier results are never starved.

## Interface
Parameters:
- DEPTH, 4: multiplier result FIFO entries; power of two, ≥ 4.
- STARVE_MAX, 8: cycles the FIFO head may wait before an ALU hold is requested.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  kill all buffered results.
- mul_instr_i  in  exe_wb_scalar_instr_t  multiplier output; may be valid any cycle; cannot be stalled.
- alu_instr_i  in  exe_wb_scalar_instr_t  ALU output; may be valid any cycle.
- wb_instr_o  out  exe_wb_scalar_instr_t  write-back port.
- mul_stall_o  out  1  issue must not start a new multiply next cycle.
- alu_stall_o  out  1  issue must not issue an ALU op next cycle.

## Operation
Output select, combinational, in priority order:
- flush_i = 1: wb_instr_o = all-zero.
- Else alu_instr_i.valid: forward alu_instr_i.
- Else FIFO non-empty: forward the FIFO head and pop it.
- Else mul_instr_i.valid: forward mul_instr_i directly (bypass, no push).
- Else: wb_instr_o = all-zero.

Push rules:
- mul_instr_i.valid, not bypassed, no flush: push at the clock edge behind the existing entries.
- Same-cycle push and pop are both legal. Count is unchanged; head advances; tail advances.
- Program order is preserved: a newer multiply never bypasses a non-empty FIFO.

mul_stall_o:
- Registered. Next value = (count_next ≥ DEPTH−2).
- The threshold covers the two multiplies that can already be in flight in the multiplier pipeline.

Starvation counter:
- Width $clog2(STARVE_MAX+1).
- Increments while the FIFO is non-empty and alu_instr_i.valid blocks the head.
- Clears on a pop, on flush, or when the FIFO is empty. Saturates at STARVE_MAX.
- alu_stall_o is registered: 1 while counter == STARVE_MAX; drops the cycle after the head pops.

Flush:
- Next edge: count, rd_ptr, wr_ptr, starvation counter, mul_stall_o and alu_stall_o all go to 0.
- Inputs valid during the flush cycle are discarded.

Overflow and underflow:
- Push with count == DEPTH is a protocol violation. Simulation assertion; the entry is dropped; state is unchanged.
- Pop never occurs on empty, by construction.

## Timing
- Reset values: count, pointers and counter 0; mul_stall_o = 0; alu_stall_o = 0. With invalid inputs, wb_instr_o is all-zero.
- Latency: ALU 0 cycles, combinational pass-through. Multiply 0 cycles on bypass; otherwise ≥ 1 cycle after push.
- Stalls: mul_stall_o and alu_stall_o change only on clk_i edges. Issue samples them and acts on the following cycle.
- Pointers: wrap modulo DEPTH. Full/empty is decided from count (width $clog2(DEPTH+1)), not from pointer equality.
- Reset mid-operation: asynchronous; all state and stall outputs go to 0 immediately.

## Structure
- drac_pkg gains MUL_WB_FIFO_DEPTH = 4 and MUL_WB_STARVE_MAX = 8. exe_wb_scalar_instr_t is reused from drac_pkg unchanged.
- One sub-module, mul_wb_fifo: a generic DEPTH-entry FIFO of exe_wb_scalar_instr_t with push/pop/flush, head, count and full.
- The arbiter, starvation counter and stall registers sit in the top module.

## Test plan
- Reset, then idle: wb_instr_o.valid = 0, mul_stall_o = 0, alu_stall_o = 0, count = 0.
- Multiply only, result 0x2A with no ALU traffic: appears on wb_instr_o in the same cycle; count stays 0.
- ALU valid in cycles 0–2 with multiplies A, B arriving in cycles 0 and 1:
  - ALU ops are output in cycles 0–2; A in cycle 3, B in cycle 4.
  - mul_stall_o rises after cycle 1 (count = 2 = DEPTH−2).
- ALU continuously valid with one queued multiply:
  - alu_stall_o = 1 in the cycle after 8 blocked cycles.
  - When the ALU goes idle the following cycle, the multiply is output.
  - alu_stall_o returns to 0 one cycle later.
- Three queued multiplies, then flush_i in the same cycle as a new multiply and an ALU result:
  - wb_instr_o is all-zero that cycle.
  - Next cycle count = 0 and both stalls are 0; the new multiply is never output.
- Count = 4 and a fifth multiply is forced: assertion fires, the entry is dropped, and the stored order of the four entries is intact.
